// File: rtl/display_pkg.sv
// Shared constants, state encoding and source-index helpers for the display arbiter.
package display_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int KILO = 1000;
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_URGENT = 2'd2,
    ST_LINGER = 2'd3
  } state_t;

  function automatic logic [SEL_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = SEL_W'(i);
    end
  endfunction

  // First set bit strictly after s in round-robin order; s itself when no other bit is set.
  function automatic logic [SEL_W-1:0] next_rr(input logic [NUM_SRC-1:0] v,
                                               input logic [SEL_W-1:0] s);
    int j;
    next_rr = s;
    for (int k = NUM_SRC - 1; k >= 1; k--) begin
      j = (int'(s) + k) % NUM_SRC;
      if (v[j]) next_rr = SEL_W'(j);
    end
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink phase generator: phase_on toggles every PERIOD cycles, restart forces the on phase.
module blink_timer #(
  parameter int unsigned PERIOD = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase_on
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      phase_on <= 1'b1;
    end else if (restart) begin
      cnt      <= '0;
      phase_on <= 1'b1;
    end else if (cnt == LAST) begin
      cnt      <= '0;
      phase_on <= ~phase_on;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates four data sources onto one 8-digit hex display with urgent preemption and linger.
// Optional digit blinking is built when DISPLAY_BLINK_EN is defined.
module display_arbiter
  import display_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 1000,
  parameter int HOLD_MS     = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 next_btn,
  input  logic [NUM_SRC-1:0]   req,
  input  logic [NUM_SRC-1:0]   urgent,
  input  logic [32*NUM_SRC-1:0] src_data,
  input  logic [7:0]           blink_digits,
  output logic [31:0]          all_data,
  output logic [SEL_W-1:0]     sel,
  output logic [NUM_SRC-1:0]   grant,
  output logic [NUM_SRC-1:0]   urgent_ack,
  output logic                 urgent_active
);

  localparam logic [31:0] HOLD_LOAD = 32'(HOLD_MS * CLK_FREQ_HZ / KILO - 1);
  localparam logic [NUM_SRC-1:0] SRC_ONE = NUM_SRC'(1);

  state_t             state, state_nx, ret_state;
  logic [SEL_W-1:0]   sel_nx, saved_sel, saved_nx, ret_sel, urg_low;
  logic [31:0]        cnt, cnt_nx;
  logic [NUM_SRC-1:0] urg_hit, ack_nx;
  logic [31:0]        disp_p0, data_nx;

  function automatic logic [31:0] blank_nibbles(input logic [31:0] w, input logic [7:0] mask);
    blank_nibbles = w;
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) blank_nibbles[4*k +: 4] = BLANK_NIBBLE;
    end
  endfunction

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    saved_nx = saved_sel;
    cnt_nx   = cnt;
    ack_nx   = '0;
    urg_hit  = urgent & req;
    urg_low  = lowest_idx(urg_hit);

    // Where an urgent episode hands the display back to.
    ret_state = ST_MANUAL;
    ret_sel   = saved_sel;
    if (req == '0) ret_state = ST_IDLE;
    else if (!req[saved_sel]) ret_sel = next_rr(req, saved_sel);

    case (state)
      ST_IDLE, ST_MANUAL: begin
        if (urg_hit != '0) begin
          state_nx = ST_URGENT;
          saved_nx = sel;
          sel_nx   = urg_low;
        end else if (req == '0) begin
          state_nx = ST_IDLE;
        end else if (state == ST_IDLE) begin
          state_nx = ST_MANUAL;
          sel_nx   = lowest_idx(req);
        end else if (!req[sel] || next_btn) begin
          sel_nx = next_rr(req, sel);
        end
      end
      ST_URGENT: begin
        if (urg_hit != '0 && urg_low < sel) begin
          sel_nx = urg_low;
        end else if (next_btn) begin
          ack_nx   = SRC_ONE << sel;
          state_nx = ret_state;
          sel_nx   = ret_sel;
        end else if (!urg_hit[sel]) begin
          state_nx = ST_LINGER;
          cnt_nx   = HOLD_LOAD;
        end
      end
      ST_LINGER: begin
        if (urg_hit != '0) begin
          state_nx = ST_URGENT;
          sel_nx   = urg_low;
        end else if (next_btn) begin
          ack_nx   = SRC_ONE << sel;
          state_nx = ret_state;
          sel_nx   = ret_sel;
        end else if (cnt == '0) begin
          state_nx = ret_state;
          sel_nx   = ret_sel;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel        <= '0;
      saved_sel  <= '0;
      cnt        <= '0;
      urgent_ack <= '0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      saved_sel  <= saved_nx;
      cnt        <= cnt_nx;
      urgent_ack <= ack_nx;
    end
  end

  assign grant         = (state == ST_IDLE) ? '0 : (SRC_ONE << sel);
  assign urgent_active = (state == ST_URGENT) || (state == ST_LINGER);
  assign disp_p0       = src_data[{sel, 5'b0} +: 32];

`ifdef DISPLAY_BLINK_EN
  logic phase_on, blink_restart;
  assign blink_restart = (sel_nx != sel);

  blink_timer #(.PERIOD(CLK_FREQ_HZ / 4)) u_blink (
    .clk      (clk),
    .reset    (reset),
    .restart  (blink_restart),
    .phase_on (phase_on)
  );

  assign data_nx = phase_on ? disp_p0 : blank_nibbles(disp_p0, blink_digits);
`else
  logic unused_blink;
  assign unused_blink = ^blink_digits;
  assign data_nx      = disp_p0;
`endif

  // Display stage: one register between the selected slice and the driver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) all_data <= '0;
    else all_data <= (state == ST_IDLE) ? '0 : data_nx;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 1000, input clock frequency in Hz (>= 1000).
REQ-002 SHALL have parameter HOLD_MS, default 1000, urgent linger time in ms after urgent request drops.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port next_btn  input  1  single-cycle debounced pulse: advance page / acknowledge urgent.
REQ-006 SHALL have port req  input  4  source i has valid data to show.
REQ-007 SHALL have port urgent  input  4  source i requests preemption (e.g. alarm ringing).
REQ-008 SHALL have port src_data  input  128  source i data at [32i+31:32i], 8 nibbles.
REQ-009 SHALL have port blink_digits  input  8  per-digit blink enable for the displayed source.
REQ-010 SHALL have port all_data  output  32  registered word for the 8-digit hex display driver.
REQ-011 SHALL have port sel  output  2  index of displayed source.
REQ-012 SHALL have port grant  output  4  one-hot displayed source, 0 in IDLE.
REQ-013 SHALL have port urgent_ack  output  4  one-cycle pulse to source acknowledged by next_btn.
REQ-014 SHALL have port urgent_active  output  1  high in URGENT and LINGER states.

Function
REQ-015 SHALL implement states IDLE, MANUAL, URGENT, LINGER.
REQ-016 IDLE: req==0; grant=0, all_data=0; any req bit -> MANUAL with sel=lowest requesting index.
REQ-017 MANUAL: next_btn advances sel round-robin to next index with req set, wrapping 3->0; sel unchanged if no other requester.
REQ-018 MANUAL: if req[sel] drops, sel moves next cycle to next requester round-robin; req==0 -> IDLE.
REQ-019 Any urgent[i]&req[i] in MANUAL/IDLE -> URGENT next cycle; saved_sel <= current sel; sel <= lowest such index.
REQ-020 URGENT: higher-priority (lower index) urgent preempts current urgent source immediately.
REQ-021 URGENT: next_btn pulses urgent_ack[sel] for one cycle, returns to MANUAL with sel=saved_sel (or next requester if req[saved_sel]=0, IDLE if req==0).
REQ-022 URGENT: urgent[sel] drops without ack -> LINGER; counter loaded with HOLD_MS*CLK_FREQ_HZ/1000-1.
REQ-023 LINGER: counter decrements each cycle; at 0 returns as in REQ-021 without ack; new urgent -> URGENT; next_btn ends linger as in REQ-021 with ack.
REQ-024 next_btn and a new urgent in the same cycle: urgent wins, next_btn ignored.
REQ-025 all_data SHALL equal src_data slice of the sel in effect, registered, one-cycle latency; grant=1<<sel outside IDLE.

Reset
REQ-026 reset SHALL asynchronously force state IDLE, sel=0, saved_sel=0, all_data=0, grant=0, urgent_ack=0, urgent_active=0, all counters 0.
REQ-027 reset mid-URGENT/LINGER SHALL drop state with no urgent_ack pulse.

Configuration
REQ-028 Macro DISPLAY_BLINK_EN defined: 2 Hz phase toggling every CLK_FREQ_HZ/4 cycles; in off phase nibble k of all_data replaced with BLANK_NIBBLE when blink_digits[k]=1; phase resets to on whenever sel changes.
REQ-029 Macro undefined: no phase counter, blink_digits ignored, all_data never blanked.

Structure
REQ-030 Shared package display_pkg SHALL hold NUM_SRC=4, KILO=1000, BLANK_NIBBLE=4'hF, state encoding.
REQ-031 Sub-module blink_timer (phase generator, restart input) SHALL be instantiated only under DISPLAY_BLINK_EN.

Verification (CLK_FREQ_HZ=1000, HOLD_MS=10)
REQ-032 Reset then req=4'b0101 -> cycle 1 sel=0, grant=0001; next cycle all_data=src_data[31:0].
REQ-033 req=4'b0101, sel=0, three next_btn pulses -> sel 2, 0, 2 (bit1/bit3 skipped).
REQ-034 sel=2, urgent=4'b0010 -> sel=1, urgent_active=1; next_btn -> urgent_ack=0010 one cycle, sel=2.
REQ-035 urgent[1] drops without ack -> sel held 1 for exactly 10 cycles in LINGER, then sel=2, no ack pulse.
REQ-036 urgent=4'b1000 then urgent=4'b1001 -> sel 3 then 0; same-cycle next_btn+urgent -> no ack.
REQ-037 DISPLAY_BLINK_EN, blink_digits=8'h01 -> all_data[3:0] alternates data/4'hF every 250 cycles; undefined -> constant.
